// File: rtl/osc_capture.sv
// rtl/osc_capture.sv - triggered circular-buffer sample capture with trigger-aligned readout
module osc_capture #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  // Terminal/reload values for the window counters, sized to the address width.
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_N);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Sample buffer; deliberately not reset so it maps onto plain RAM.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [DATA_W-1:0] r_prev;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_start_addr;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_pre_cnt_nxt;
  logic [ADDR_W-1:0] w_post_cnt_nxt;
  logic [DATA_W-1:0] w_prev_nxt;
  logic [ADDR_W-1:0] w_trig_addr_nxt;
  logic [ADDR_W-1:0] w_start_addr_nxt;

  logic              w_capturing;
  logic              w_we;
  logic              w_rise;
  logic              w_fall;
  logic              w_hit;
  logic              w_rd_fire;
  logic [ADDR_W-1:0] w_rd_phys;

  // Writes are only taken while a capture is running; arm wins over a same-edge sample.
  assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_we        = sample_valid && !arm && w_capturing;

  // Trigger is a crossing of the level between the last written sample and the current one.
  assign w_rise = (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_fall = (r_prev > trig_level) && (sample_in <= trig_level);
  assign w_hit  = trig_edge ? w_fall : w_rise;

  // Reads address the frozen window relative to its oldest sample, wrapping naturally.
  assign w_rd_phys = r_start_addr + rd_addr;
  assign w_rd_fire = rd_en && (r_state == S_DONE);

  // Next-state and counter update for the capture sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_pre_cnt_nxt    = r_pre_cnt;
    w_post_cnt_nxt   = r_post_cnt;
    w_prev_nxt       = r_prev;
    w_trig_addr_nxt  = r_trig_addr;
    w_start_addr_nxt = r_start_addr;

    if (arm) begin
      w_state_nxt    = S_PRE;
      w_wr_ptr_nxt   = '0;
      w_pre_cnt_nxt  = '0;
      w_post_cnt_nxt = '0;
    end else if (w_we) begin
      w_wr_ptr_nxt = r_wr_ptr + ONE;
      w_prev_nxt   = sample_in;
      case (r_state)
        S_PRE: begin
          if (r_pre_cnt == PRE_LAST) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_pre_cnt_nxt = r_pre_cnt + ONE;
          end
        end
        S_WAIT: begin
          if (w_hit) begin
            w_trig_addr_nxt  = r_wr_ptr;
            w_start_addr_nxt = r_wr_ptr - PRE_OFS;
            if (POST_N == 0) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt    = S_POST;
              w_post_cnt_nxt = POST_INIT;
            end
          end
        end
        S_POST: begin
          w_post_cnt_nxt = r_post_cnt - ONE;
          if (r_post_cnt == ONE) begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Sequencer registers; busy/done are decoded from the next state so they track it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_prev       <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_pre_cnt    <= w_pre_cnt_nxt;
      r_post_cnt   <= w_post_cnt_nxt;
      r_prev       <= w_prev_nxt;
      r_trig_addr  <= w_trig_addr_nxt;
      r_start_addr <= w_start_addr_nxt;
      r_busy       <= (w_state_nxt == S_PRE) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_POST);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Buffer write port, one sample per accepted edge at the write pointer.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  // Registered read port; data holds between requests, valid pulses once per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= r_mem[w_rd_phys];
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign trig_addr  = r_trig_addr;
  assign start_addr = r_start_addr;

endmodule

// File: tb/tb_osc_capture.sv
// tb/tb_osc_capture.sv - directed self-checking bench for osc_capture
module tb_osc_capture;

  logic       clk;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       arm;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [7:0] trig_addr;
  logic [7:0] start_addr;

  int n_checks;
  int n_errors;

  osc_capture #(.DATA_W(8), .ADDR_W(8), .PRE_TRIG(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .arm         (arm),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Feed ramp samples first..first+n-1, each followed by 'gap' idle cycles.
  task automatic feed(input int first, input int n, input bit down, input int gap);
    for (int i = 0; i < n; i++) begin
      int v;
      v = (first + i) % 256;
      sample_in    = down ? 8'(255 - v) : 8'(v);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic read_one(input string tag, input int addr, input int exp);
    rd_en   = 1'b1;
    rd_addr = 8'(addr);
    tick();
    rd_en = 1'b0;
    check_val({tag, "_valid"}, int'(rd_valid), 1);
    check_val({tag, "_data"}, int'(rd_data), exp);
  endtask

  // Rising ramp at level 128: window ends after the 320th sample.
  task automatic run_rising(input string tag, input int gap);
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    check_val({tag, "_busy_armed"}, int'(busy), 1);
    feed(0, 319, 1'b0, gap);
    check_val({tag, "_done_319"}, int'(done), 0);
    check_val({tag, "_busy_319"}, int'(busy), 1);
    feed(319, 1, 1'b0, 0);
    check_val({tag, "_done_320"}, int'(done), 1);
    check_val({tag, "_busy_320"}, int'(busy), 0);
    check_val({tag, "_trig_addr"}, int'(trig_addr), 128);
    check_val({tag, "_start_addr"}, int'(start_addr), 64);
    read_one({tag, "_rd0"}, 0, 64);
    read_one({tag, "_rd64"}, 64, 128);
    read_one({tag, "_rd255"}, 255, 63);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    trig_level   = '0;
    trig_edge    = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;

    #3;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_rd_valid", int'(rd_valid), 0);
    check_val("rst_rd_data", int'(rd_data), 0);
    check_val("rst_trig_addr", int'(trig_addr), 0);
    check_val("rst_start_addr", int'(start_addr), 0);
    #4;
    rst = 1'b0;
    tick();

    // Reads in IDLE are ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val("idle_rd_valid", int'(rd_valid), 0);

    run_rising("ramp", 0);

    // Falling ramp at level 100: trigger sample 100 lands at address 155.
    trig_level = 8'd100;
    trig_edge  = 1'b1;
    do_arm();
    feed(0, 346, 1'b1, 0);
    check_val("fall_done_346", int'(done), 0);
    feed(346, 1, 1'b1, 0);
    check_val("fall_done_347", int'(done), 1);
    check_val("fall_trig_addr", int'(trig_addr), 155);
    check_val("fall_start_addr", int'(start_addr), 91);
    read_one("fall_rd64", 64, 100);
    read_one("fall_rd63", 63, 101);
    read_one("fall_rd0", 0, 164);

    run_rising("gap", 2);

    // Arm abort mid-POST, then a constant below the level never triggers.
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    feed(0, 200, 1'b0, 0);
    check_val("abort_post_busy", int'(busy), 1);
    check_val("abort_post_trig", int'(trig_addr), 128);
    do_arm();
    for (int i = 0; i < 300; i++) begin
      sample_in    = 8'd50;
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check_val("abort_busy", int'(busy), 1);
    check_val("abort_done", int'(done), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val("abort_rd_valid", int'(rd_valid), 0);

    // Asynchronous reset in WAIT_TRIG, checked before any further clock edge.
    trig_level = 8'd200;
    do_arm();
    feed(0, 100, 1'b0, 0);
    check_val("pre_rst_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_done", int'(done), 0);
    check_val("mid_rst_rd_valid", int'(rd_valid), 0);
    check_val("mid_rst_rd_data", int'(rd_data), 0);
    check_val("mid_rst_trig_addr", int'(trig_addr), 0);
    check_val("mid_rst_start_addr", int'(start_addr), 0);
    rst = 1'b0;
    tick();
    run_rising("after_rst", 0);

    // Burst read of the whole window, one sample per cycle.
    rd_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i);
      tick();
      check_val("burst_valid", int'(rd_valid), 1);
      check_val("burst_data", int'(rd_data), (64 + i) % 256);
    end
    rd_en = 1'b0;
    tick();
    check_val("burst_end_valid", int'(rd_valid), 0);

    // Arm and read on the same edge: read is served from the old window.
    arm     = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 8'd64;
    tick();
    arm   = 1'b0;
    rd_en = 1'b0;
    check_val("armrd_valid", int'(rd_valid), 1);
    check_val("armrd_data", int'(rd_data), 128);
    check_val("armrd_busy", int'(busy), 1);
    check_val("armrd_done", int'(done), 0);
    tick();
    check_val("armrd_valid_drop", int'(rd_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
